// File: rtl/regfile_pkg.sv
// Shared types, reset constants and the write-port bypass priority search
// for the multi-port register file.
package regfile_pkg;

  localparam int REG_AWIDTH = 5;
  localparam int REG_DWIDTH = 32;

  localparam logic [31:0] PC_START  = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH = 32'h0001_0000;

  localparam int SP_REG_IDX   = 2;
  localparam int ZERO_REG_IDX = 0;

  // Upper bound on write ports the bypass search can arbitrate.
  localparam int MAX_WR_PORTS = 8;
  localparam int SEL_W        = $clog2(MAX_WR_PORTS);

  typedef logic [REG_AWIDTH-1:0] reg_addr_t;
  typedef logic [REG_DWIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } bypass_sel_t;

  // Highest-index matching write port wins.
  function automatic bypass_sel_t bypass_select(input logic [MAX_WR_PORTS-1:0] match);
    bypass_sel_t sel;
    sel.hit = 1'b0;
    sel.idx = '0;
    for (int j = 0; j < MAX_WR_PORTS; j++) begin
      if (match[j]) begin
        sel.hit = 1'b1;
        sel.idx = SEL_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by ID marks, cleared by
// WB writes or a pipeline flush, with a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AWIDTH   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REGS-1:0]             clr_i,
  input  logic                            mark_en_i,
  input  logic [AWIDTH-1:0]               mark_addr_i,
  input  logic                            flush_i,
  output logic [NUM_REGS-1:0]             pend_o,
  output logic [$clog2(NUM_REGS+1)-1:0]   count_o
);

  localparam int CW = $clog2(NUM_REGS+1);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CW-1:0]       count_q, count_d;

  always_comb begin
    pend_d = pend_q & ~clr_i;
    // Mark after clear: a newer producer supersedes the retiring write.
    for (int r = ZERO_REG_IDX + 1; r < NUM_REGS; r++) begin
      if (mark_en_i && mark_addr_i == AWIDTH'(r)) begin
        pend_d[r] = 1'b1;
      end
    end
    if (flush_i) begin
      pend_d = '0;
    end
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + CW'(pend_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign pend_o  = pend_q;
  assign count_o = count_q;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-first bypass, raw probe outputs and a
// pending-write scoreboard for RAW hazard detection in ID.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int               DWIDTH   = 32,
  parameter int               AWIDTH   = 5,
  parameter int               NUM_REGS = 32,
  parameter int               NUM_RD   = 2,
  parameter int               NUM_WR   = 1,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(PC_START + MEM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*AWIDTH-1:0]      rs_addr_i,
  output logic [NUM_RD*DWIDTH-1:0]      rs_data_o,
  output logic [NUM_RD*DWIDTH-1:0]      rs_data_raw_o,
  output logic [NUM_RD-1:0]             rs_busy_o,
  input  logic [NUM_WR-1:0]             we_i,
  input  logic [NUM_WR*AWIDTH-1:0]      wr_addr_i,
  input  logic [NUM_WR*DWIDTH-1:0]      wr_data_i,
  input  logic                          mark_en_i,
  input  logic [AWIDTH-1:0]             mark_addr_i,
  input  logic                          flush_i,
  output logic [$clog2(NUM_REGS+1)-1:0] busy_count_o
);

  logic [DWIDTH-1:0]   regs_q [NUM_REGS];
  logic [DWIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] pend;

  // Ascending port loop makes the highest-index port win on a collision.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < NUM_WR; j++) begin
      for (int r = ZERO_REG_IDX + 1; r < NUM_REGS; r++) begin
        if (we_i[j] && wr_addr_i[j*AWIDTH +: AWIDTH] == AWIDTH'(r)) begin
          regs_d[r] = wr_data_i[j*DWIDTH +: DWIDTH];
          wr_hit[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= (r == SP_REG_IDX) ? SP_INIT : '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AWIDTH-1:0]       addr;
    logic [DWIDTH-1:0]       raw;
    logic                    pend_bit;
    logic                    wr_now;
    logic [MAX_WR_PORTS-1:0] match;
    bypass_sel_t             sel;

    assign addr = rs_addr_i[gi*AWIDTH +: AWIDTH];

    // Out-of-range addresses never match, so they read 0 and are never busy.
    always_comb begin
      raw      = '0;
      pend_bit = 1'b0;
      wr_now   = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr == AWIDTH'(r)) begin
          raw      = regs_q[r];
          pend_bit = pend[r];
          wr_now   = wr_hit[r];
        end
      end
      match = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        match[j] = we_i[j] && (wr_addr_i[j*AWIDTH +: AWIDTH] == addr) && wr_now;
      end
    end

    assign sel = bypass_select(match);

    assign rs_data_raw_o[gi*DWIDTH +: DWIDTH] = raw;
    assign rs_data_o[gi*DWIDTH +: DWIDTH] =
      sel.hit ? wr_data_i[int'(sel.idx)*DWIDTH +: DWIDTH] : raw;
    assign rs_busy_o[gi] = pend_bit & ~wr_now;
  end

  regfile_scoreboard #(
    .AWIDTH   (AWIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (wr_hit),
    .mark_en_i   (mark_en_i),
    .mark_addr_i (mark_addr_i),
    .flush_i     (flush_i),
    .pend_o      (pend),
    .count_o     (busy_count_o)
  );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: directed vector table, a mid-cycle reset
// sequence, then randomized traffic against a behavioural array model.
module tb_regfile_mp_scoreboard;

  localparam logic [31:0] SP_EXP = 32'h0101_0000;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr_i;
  logic [63:0] rs_data_o;
  logic [63:0] rs_data_raw_o;
  logic [1:0]  rs_busy_o;
  logic [1:0]  we_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        mark_en_i;
  logic [4:0]  mark_addr_i;
  logic        flush_i;
  logic [5:0]  busy_count_o;

  int checks   = 0;
  int failures = 0;

  regfile_mp_scoreboard #(
    .DWIDTH   (32),
    .AWIDTH   (5),
    .NUM_REGS (32),
    .NUM_RD   (2),
    .NUM_WR   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs_addr_i     (rs_addr_i),
    .rs_data_o     (rs_data_o),
    .rs_data_raw_o (rs_data_raw_o),
    .rs_busy_o     (rs_busy_o),
    .we_i          (we_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .mark_en_i     (mark_en_i),
    .mark_addr_i   (mark_addr_i),
    .flush_i       (flush_i),
    .busy_count_o  (busy_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents and pending flags as plain arrays.
  logic [31:0] m_mem [32];
  bit          m_pend [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_mem[2] = SP_EXP;
  endfunction

  function automatic logic [4:0] wa(int j);
    return (j == 0) ? wr_addr_i[4:0] : wr_addr_i[9:5];
  endfunction

  function automatic logic [31:0] wd(int j);
    return (j == 0) ? wr_data_i[31:0] : wr_data_i[63:32];
  endfunction

  function automatic bit m_written(int a);
    bit w = 1'b0;
    for (int j = 0; j < 2; j++) if (we_i[j] && int'(wa(j)) == a && a != 0) w = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] m_raw(int a);
    return (a == 0) ? 32'h0 : m_mem[a];
  endfunction

  function automatic logic [31:0] m_data(int a);
    logic [31:0] d = m_raw(a);
    for (int j = 0; j < 2; j++) if (we_i[j] && int'(wa(j)) == a && a != 0) d = wd(j);
    return d;
  endfunction

  function automatic bit m_busy(int a);
    return m_pend[a] && !m_written(a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic void model_step();
    for (int j = 0; j < 2; j++) begin
      if (we_i[j] && wa(j) != 0) begin
        m_mem[wa(j)]  = wd(j);
        m_pend[wa(j)] = 1'b0;
      end
    end
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (mark_en_i && mark_addr_i != 0) begin
      m_pend[mark_addr_i] = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we_i        = '0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    mark_en_i   = 1'b0;
    mark_addr_i = '0;
    flush_i     = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        mk;
    logic [4:0]  ma;
    logic        fl;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    //            we     wa0  wd0            wa1  wd1      ra0  ra1  mk  ma   fl  d0            d1            r0            r1            busy   cnt
    tbl[0]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd1, 5'd2, 1'b0, 5'd0,  1'b0, 32'h0,        SP_EXP,       32'h0,        SP_EXP,       2'b00, 6'd0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd0, 5'd2, 1'b0, 5'd0,  1'b0, 32'h0,        SP_EXP,       32'h0,        SP_EXP,       2'b00, 6'd0};
    tbl[2]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0,  32'h0,   5'd5, 5'd5, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd5, 5'd0, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
    tbl[4]  = '{2'b11, 5'd0, 32'h1,        5'd0,  32'h1,   5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 6'd0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd0, 5'd5, 1'b0, 5'd0,  1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    tbl[6]  = '{2'b11, 5'd7, 32'h11,       5'd7,  32'h22,  5'd7, 5'd7, 1'b0, 5'd0,  1'b0, 32'h22,       32'h22,       32'h0,        32'h0,        2'b00, 6'd0};
    tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd7, 5'd7, 1'b0, 5'd0,  1'b0, 32'h22,       32'h22,       32'h22,       32'h22,       2'b00, 6'd0};
    tbl[8]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd3, 5'd3, 1'b1, 5'd3,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 6'd1};
    tbl[9]  = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd3, 5'd2, 1'b0, 5'd0,  1'b0, 32'h0,        SP_EXP,       32'h0,        SP_EXP,       2'b01, 6'd1};
    tbl[10] = '{2'b01, 5'd3, 32'h33,       5'd0,  32'h0,   5'd3, 5'd3, 1'b1, 5'd3,  1'b0, 32'h33,       32'h33,       32'h0,        32'h0,        2'b00, 6'd1};
    tbl[11] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd3, 5'd3, 1'b0, 5'd0,  1'b0, 32'h33,       32'h33,       32'h33,       32'h33,       2'b11, 6'd1};
    tbl[12] = '{2'b01, 5'd3, 32'h44,       5'd0,  32'h0,   5'd3, 5'd0, 1'b0, 5'd0,  1'b0, 32'h44,       32'h0,        32'h33,       32'h0,        2'b00, 6'd0};
    tbl[13] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd3, 5'd3, 1'b0, 5'd0,  1'b0, 32'h44,       32'h44,       32'h44,       32'h44,       2'b00, 6'd0};
    tbl[14] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd4, 5'd6, 1'b1, 5'd4,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 6'd1};
    tbl[15] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd4, 5'd6, 1'b1, 5'd6,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b01, 6'd2};
    tbl[16] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd6, 5'd9, 1'b1, 5'd9,  1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b01, 6'd3};
    tbl[17] = '{2'b10, 5'd0, 32'h0,        5'd11, 32'hAB,  5'd9, 5'd11, 1'b1, 5'd10, 1'b1, 32'h0,       32'hAB,       32'h0,        32'h0,        2'b01, 6'd0};
    tbl[18] = '{2'b00, 5'd0, 32'h0,        5'd0,  32'h0,   5'd10, 5'd11, 1'b0, 5'd0, 1'b0, 32'h0,       32'hAB,       32'h0,        32'hAB,       2'b00, 6'd0};

    rst       = 1'b0;
    rs_addr_i = {5'd2, 5'd0};
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", rs_data_o[63:32], SP_EXP);
    chk("rst_cnt", 32'(busy_count_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      we_i        = tbl[i].we;
      wr_addr_i   = {tbl[i].wa1, tbl[i].wa0};
      wr_data_i   = {tbl[i].wd1, tbl[i].wd0};
      rs_addr_i   = {tbl[i].ra1, tbl[i].ra0};
      mark_en_i   = tbl[i].mk;
      mark_addr_i = tbl[i].ma;
      flush_i     = tbl[i].fl;
      #1;
      $display("vec %0d: d0=%h d1=%h busy=%b", i, rs_data_o[31:0], rs_data_o[63:32], rs_busy_o);
      chk($sformatf("vec%0d_d0", i), rs_data_o[31:0], tbl[i].d0);
      chk($sformatf("vec%0d_d1", i), rs_data_o[63:32], tbl[i].d1);
      chk($sformatf("vec%0d_r0", i), rs_data_raw_o[31:0], tbl[i].r0);
      chk($sformatf("vec%0d_r1", i), rs_data_raw_o[63:32], tbl[i].r1);
      chk($sformatf("vec%0d_busy", i), 32'(rs_busy_o), 32'(tbl[i].busy));
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i), 32'(busy_count_o), 32'(tbl[i].cnt));
    end

    // Mark x4 and x5, then pull reset low mid-cycle while both are pending.
    for (int k = 4; k <= 5; k++) begin
      @(negedge clk);
      idle_inputs();
      mark_en_i   = 1'b1;
      mark_addr_i = 5'(k);
      model_step();
    end
    @(negedge clk);
    idle_inputs();
    rs_addr_i = {5'd5, 5'd4};
    #1;
    chk("pre_rst_busy", 32'(rs_busy_o), 32'h3);
    chk("pre_rst_cnt", 32'(busy_count_o), 32'd2);
    chk("pre_rst_x5", rs_data_o[63:32], 32'hDEADBEEF);
    #1;
    rst = 1'b0;
    #1;
    $display("mid-cycle reset: busy=%b cnt=%0d", rs_busy_o, busy_count_o);
    chk("async_rst_busy", 32'(rs_busy_o), 32'h0);
    chk("async_rst_cnt", 32'(busy_count_o), 32'd0);
    chk("async_rst_x5", rs_data_o[63:32], 32'h0);
    rs_addr_i = {5'd2, 5'd7};
    #1;
    chk("async_rst_sp", rs_data_raw_o[63:32], SP_EXP);
    chk("async_rst_x7", rs_data_o[31:0], 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int a0, a1;
      @(negedge clk);
      we_i        = 2'($urandom);
      wr_addr_i   = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wr_data_i   = {32'($urandom), 32'($urandom)};
      a0          = int'($urandom_range(0, 15));
      a1          = int'($urandom_range(0, 15));
      rs_addr_i   = {5'(a1), 5'(a0)};
      mark_en_i   = 1'($urandom);
      mark_addr_i = 5'($urandom_range(0, 15));
      flush_i     = ($urandom_range(0, 15) == 0);
      #1;
      $display("rnd %0d: ra=%0d,%0d we=%b busy=%b cnt=%0d", i, a0, a1, we_i, rs_busy_o, busy_count_o);
      chk("rnd_d0", rs_data_o[31:0], m_data(a0));
      chk("rnd_d1", rs_data_o[63:32], m_data(a1));
      chk("rnd_r0", rs_data_raw_o[31:0], m_raw(a0));
      chk("rnd_r1", rs_data_raw_o[63:32], m_raw(a1));
      chk("rnd_busy", 32'(rs_busy_o), 32'({m_busy(a1), m_busy(a0)}));
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_cnt", 32'(busy_count_o), 32'(m_count()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
